// File: rtl/tl_xbar_pkg.sv
// Shared TileLink-UL definitions for the N-to-1 crossbar: opcodes, field widths,
// packed-beat offsets and the beat-count rule.
package tl_xbar_pkg;

   localparam logic [2:0] TL_PUT_FULL        = 3'd0;
   localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
   localparam logic [2:0] TL_ARITH           = 3'd2;
   localparam logic [2:0] TL_LOGIC           = 3'd3;
   localparam logic [2:0] TL_GET             = 3'd4;
   localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
   localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

   localparam int TL_OPC_W         = 32'sd3;
   localparam int TL_A_PARAM_W     = 32'sd3;
   localparam int TL_D_PARAM_W     = 32'sd2;
   localparam int TL_A_CORRUPT_LSB = 32'sd0;
   localparam int TL_A_DATA_LSB    = 32'sd1;
   localparam int TL_D_CORRUPT_LSB = 32'sd0;
   localparam int TL_D_DATA_LSB    = 32'sd1;

   function automatic int tl_idx_w(input int n_in);
      return (n_in > 32'sd1) ? $clog2(n_in) : 32'sd1;
   endfunction

   // A beat: {opcode, param, size, source, address, mask, data, corrupt}
   function automatic int tl_a_src_lsb(input int addr_w, input int data_w);
      return TL_A_DATA_LSB + data_w + data_w / 32'sd8 + addr_w;
   endfunction

   function automatic int tl_a_w(input int src_w, input int addr_w, input int data_w, input int size_w);
      return tl_a_src_lsb(addr_w, data_w) + src_w + size_w + TL_A_PARAM_W + TL_OPC_W;
   endfunction

   // D beat: {opcode, param, size, source, sink, denied, data, corrupt}
   function automatic int tl_d_src_lsb(input int data_w);
      return TL_D_DATA_LSB + data_w + 32'sd2;
   endfunction

   function automatic int tl_d_w(input int src_w, input int data_w, input int size_w);
      return tl_d_src_lsb(data_w) + src_w + size_w + TL_D_PARAM_W + TL_OPC_W;
   endfunction

   function automatic int unsigned tl_num_beats(input logic [2:0] opcode, input logic [7:0] size,
                                                input int unsigned beat_lg);
      int unsigned beats;
      if ((opcode <= TL_LOGIC) && (32'(size) > beat_lg)) begin
         beats = 32'd1 << (32'(size) - beat_lg);
      end else begin
         beats = 32'd1;
      end
      return beats;
   endfunction

endpackage

// File: rtl/tl_xbar_nto1_if.sv
// Client-side and manager-side TileLink-UL channels of the N-to-1 crossbar,
// with the crossbar (slave) and environment (master) views.
interface tl_xbar_nto1_if #(
   parameter int N_IN   = 2,
   parameter int SRC_W  = 3,
   parameter int ADDR_W = 31,
   parameter int DATA_W = 64,
   parameter int SIZE_W = 3
);
   import tl_xbar_pkg::*;

   localparam int IDX_W = tl_idx_w(N_IN);
   localparam int A_W   = tl_a_w(SRC_W, ADDR_W, DATA_W, SIZE_W);
   localparam int D_W   = tl_d_w(SRC_W, DATA_W, SIZE_W);

   logic [N_IN-1:0]       in_a_valid;
   logic [N_IN-1:0]       in_a_ready;
   logic [N_IN*A_W-1:0]   in_a_bits;
   logic [N_IN-1:0]       in_d_valid;
   logic [N_IN-1:0]       in_d_ready;
   logic [N_IN*D_W-1:0]   in_d_bits;
   logic                  out_a_valid;
   logic                  out_a_ready;
   logic [A_W+IDX_W-1:0]  out_a_bits;
   logic                  out_d_valid;
   logic                  out_d_ready;
   logic [D_W+IDX_W-1:0]  out_d_bits;
   logic                  route_err;

   modport slave (
      input  in_a_valid, in_a_bits, in_d_ready, out_a_ready, out_d_valid, out_d_bits,
      output in_a_ready, in_d_valid, in_d_bits, out_a_valid, out_a_bits, out_d_ready, route_err
   );

   modport master (
      output in_a_valid, in_a_bits, in_d_ready, out_a_ready, out_d_valid, out_d_bits,
      input  in_a_ready, in_d_valid, in_d_bits, out_a_valid, out_a_bits, out_d_ready, route_err
   );

endinterface

// File: rtl/tl_xbar_nto1_arb.sv
// N-way round-robin arbiter: grants the first requester at or above ptr (wrapping),
// or the held owner while locked.
module tl_rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   input  logic             lock_i,
   input  logic [IDX_W-1:0] owner_i,
   output logic             gnt_valid_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic [N-1:0]     gnt_oh_o
);

   logic             scan_found_s;
   logic [IDX_W-1:0] scan_idx_s;
   int               dist_s;
   int               best_dist_s;

   // Smallest wrap distance from ptr among requesters wins
   always_comb begin
      scan_found_s = 1'b0;
      scan_idx_s   = '0;
      dist_s       = 32'sd0;
      best_dist_s  = N;
      for (int i = 0; i < N; i++) begin
         dist_s = (i + N - int'(ptr_i)) % N;
         if (req_i[i] && (dist_s < best_dist_s)) begin
            best_dist_s  = dist_s;
            scan_idx_s   = IDX_W'(i);
            scan_found_s = 1'b1;
         end else begin
            best_dist_s = best_dist_s;
         end
      end
   end

   always_comb begin
      gnt_oh_o = '0;
      if (lock_i) begin
         gnt_idx_o   = owner_i;
         gnt_valid_o = 1'b1;
      end else begin
         gnt_idx_o   = scan_idx_s;
         gnt_valid_o = scan_found_s;
      end
      for (int i = 0; i < N; i++) begin
         gnt_oh_o[i] = gnt_valid_o && (gnt_idx_o == IDX_W'(i));
      end
   end

endmodule

// File: rtl/tl_xbar_nto1.sv
// N-input to 1-output TileLink-UL crossbar: round-robin A arbitration with burst
// locking and source widening; D responses routed back by the source index.
module tl_xbar_nto1
   import tl_xbar_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int SRC_W  = 3,
   parameter int ADDR_W = 31,
   parameter int DATA_W = 64,
   parameter int SIZE_W = 3
) (
   input logic           clock,
   input logic           reset,
   tl_xbar_nto1_if.slave bus
);

   localparam int IDX_W      = tl_idx_w(N_IN);
   localparam int BEAT_LG    = $clog2(DATA_W / 32'sd8);
   localparam int A_W        = tl_a_w(SRC_W, ADDR_W, DATA_W, SIZE_W);
   localparam int D_W        = tl_d_w(SRC_W, DATA_W, SIZE_W);
   localparam int A_SIZE_LSB = tl_a_src_lsb(ADDR_W, DATA_W) + SRC_W;
   localparam int A_OPC_LSB  = A_SIZE_LSB + SIZE_W + TL_A_PARAM_W;
   localparam int D_IDX_LSB  = tl_d_src_lsb(DATA_W) + SRC_W;
   localparam int MAX_SHIFT  = (32'sd1 << SIZE_W) - 32'sd1 - BEAT_LG;
   // Counter holds beats still to go including the pending one, up to 2^MAX_SHIFT
   localparam int CNT_W      = ((MAX_SHIFT > 32'sd0) ? MAX_SHIFT : 32'sd0) + 32'sd1;

   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic             locked_q, locked_d;
   logic [CNT_W-1:0] beats_left_q, beats_left_d;
   logic             route_err_q, route_err_d;

   logic             gnt_valid_s;
   logic [IDX_W-1:0] gnt_idx_s;
   logic [N_IN-1:0]  gnt_oh_s;
   logic [A_W-1:0]   sel_bits_s;
   logic [CNT_W-1:0] msg_beats_s;
   logic             a_valid_s;
   logic             a_fire_s;
   logic             last_beat_s;
   logic [IDX_W-1:0] next_ptr_s;

   logic [IDX_W-1:0] d_idx_s;
   logic             d_idx_ok_s;
   logic             d_sel_ready_s;
   logic [N_IN-1:0]  d_valid_s;
   logic [D_W-1:0]   d_bits_s;

   tl_rr_arbiter #(.N(N_IN), .IDX_W(IDX_W)) u_arb (
      .req_i       (bus.in_a_valid),
      .ptr_i       (rr_ptr_q),
      .lock_i      (locked_q),
      .owner_i     (owner_q),
      .gnt_valid_o (gnt_valid_s),
      .gnt_idx_o   (gnt_idx_s),
      .gnt_oh_o    (gnt_oh_s)
   );

   always_comb begin
      sel_bits_s = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (gnt_idx_s == IDX_W'(i)) begin
            sel_bits_s = bus.in_a_bits[i*A_W +: A_W];
         end else begin
            sel_bits_s = sel_bits_s;
         end
      end
   end

   assign msg_beats_s = CNT_W'(tl_num_beats(sel_bits_s[A_OPC_LSB +: 3], 8'(sel_bits_s[A_SIZE_LSB +: SIZE_W]),
                                            BEAT_LG));
   assign a_valid_s   = !reset && (|bus.in_a_valid);
   assign a_fire_s    = a_valid_s && gnt_valid_s && bus.out_a_ready;
   assign last_beat_s = locked_q ? (beats_left_q == CNT_W'(1)) : (msg_beats_s == CNT_W'(1));
   assign next_ptr_s  = (32'(gnt_idx_s) == 32'(N_IN - 32'sd1)) ? '0 : gnt_idx_s + IDX_W'(1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         locked_q     <= 1'b0;
         beats_left_q <= '0;
         route_err_q  <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         owner_q      <= owner_d;
         locked_q     <= locked_d;
         beats_left_q <= beats_left_d;
         route_err_q  <= route_err_d;
      end
   end

   // A stalled first beat locks too, so grant and bits cannot move while waiting
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      owner_d      = owner_q;
      locked_d     = locked_q;
      beats_left_d = beats_left_q;
      if (a_fire_s) begin
         if (last_beat_s) begin
            locked_d     = 1'b0;
            beats_left_d = '0;
            rr_ptr_d     = next_ptr_s;
         end else if (locked_q) begin
            beats_left_d = beats_left_q - CNT_W'(1);
         end else begin
            locked_d     = 1'b1;
            owner_d      = gnt_idx_s;
            beats_left_d = msg_beats_s - CNT_W'(1);
         end
      end else if (a_valid_s && !locked_q) begin
         locked_d     = 1'b1;
         owner_d      = gnt_idx_s;
         beats_left_d = msg_beats_s;
      end else begin
         locked_d = locked_q;
      end
   end

   always_comb begin
      d_idx_s       = (N_IN == 32'sd1) ? '0 : bus.out_d_bits[D_IDX_LSB +: IDX_W];
      d_idx_ok_s    = (32'(d_idx_s) < 32'(N_IN));
      d_sel_ready_s = 1'b0;
      d_valid_s     = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (d_idx_s == IDX_W'(i)) begin
            d_sel_ready_s = bus.in_d_ready[i];
            d_valid_s[i]  = bus.out_d_valid;
         end else begin
            d_valid_s[i]  = 1'b0;
         end
      end
   end

   assign d_bits_s    = {bus.out_d_bits[D_W+IDX_W-1:D_IDX_LSB+IDX_W], bus.out_d_bits[D_IDX_LSB-1:0]};
   assign route_err_d = route_err_q | (bus.out_d_valid & ~d_idx_ok_s);

   assign bus.out_a_valid = a_valid_s;
   assign bus.out_a_bits  = {sel_bits_s[A_W-1:A_SIZE_LSB], gnt_idx_s, sel_bits_s[A_SIZE_LSB-1:0]};
   assign bus.in_a_ready  = (!reset && bus.out_a_ready) ? gnt_oh_s : '0;
   assign bus.in_d_valid  = reset ? '0 : d_valid_s;
   assign bus.in_d_bits   = {N_IN{d_bits_s}};
   assign bus.out_d_ready = !reset && (d_idx_ok_s ? d_sel_ready_s : 1'b1);
   assign bus.route_err   = route_err_q;

endmodule

// File: tb/tb_tl_xbar_nto1.sv
// Directed bench for tl_xbar_nto1: a 2-input instance checked every cycle against a
// message-level arbitration/routing model, plus a 3-input instance for bad-index routing.
module tb_tl_xbar_nto1;

   localparam int SRC_W  = 3;
   localparam int ADDR_W = 31;
   localparam int DATA_W = 64;
   localparam int SIZE_W = 3;
   localparam int A_W    = 3 + 3 + SIZE_W + SRC_W + ADDR_W + DATA_W / 8 + DATA_W + 1;
   localparam int A_SRC  = 1 + DATA_W + DATA_W / 8 + ADDR_W;
   localparam int A_SIZE = A_SRC + SRC_W;
   localparam int A_OPC  = A_SIZE + SIZE_W + 3;
   localparam int D_W    = 3 + 2 + SIZE_W + SRC_W + 1 + 1 + DATA_W + 1;
   localparam int D_SRC  = DATA_W + 3;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   tl_xbar_nto1_if #(.N_IN(2)) b2 ();
   tl_xbar_nto1_if #(.N_IN(3)) b3 ();

   tl_xbar_nto1 #(.N_IN(2)) dut2 (.clock(clk), .reset(rst), .bus(b2.slave));
   tl_xbar_nto1 #(.N_IN(3)) dut3 (.clock(clk), .reset(rst), .bus(b3.slave));

   always #5 clk = ~clk;

   logic [A_W-1:0] aq[2][$];
   int             fire_log[$];
   logic [3:0]     src_log[$];
   logic [3:0]     stall_src;
   int             m_hold;
   int             m_left;
   int             m_ptr;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [A_W-1:0] mk_a(input logic [2:0] opc, input logic [2:0] size,
                                           input logic [2:0] src, input logic [63:0] data);
      return {opc, 3'd0, size, src, 31'h0000_1000, 8'hFF, data, 1'b0};
   endfunction

   function automatic logic [A_W:0] exp_out_a(input logic [A_W-1:0] b, input logic idx);
      return {b[A_W-1:A_SIZE], idx, b[A_SIZE-1:0]};
   endfunction

   // Puts and atomics wider than one 8-byte beat span 2^(size-3) beats
   function automatic int model_beats(input logic [A_W-1:0] b);
      int opc;
      int size;
      opc  = int'(b[A_OPC +: 3]);
      size = int'(b[A_SIZE +: 3]);
      return (opc < 4 && size > 3) ? (1 << (size - 3)) : 1;
   endfunction

   function automatic logic [31:0] order(input int first, input int n);
      logic [31:0] r;
      r = 32'h0;
      for (int k = 0; k < n; k++) begin
         r = {r[27:0], (first + k < fire_log.size()) ? 4'(fire_log[first + k]) : 4'hF};
      end
      return r;
   endfunction

   task automatic apply();
      for (int i = 0; i < 2; i++) begin
         b2.in_a_valid[i]           = (aq[i].size() > 0);
         b2.in_a_bits[i*A_W +: A_W] = (aq[i].size() > 0) ? aq[i][0] : '0;
      end
   endtask

   task automatic check2();
      logic [1:0]     vld;
      logic [1:0]     exp_rdy;
      logic           didx;
      logic [D_W-1:0] dstrip;
      int             g;
      vld = b2.in_a_valid;
      if (rst) begin
         chk("rst_out_a_valid", 128'(b2.out_a_valid), 128'h0);
         chk("rst_in_a_ready", 128'(b2.in_a_ready), 128'h0);
         chk("rst_in_d_valid", 128'(b2.in_d_valid), 128'h0);
         chk("rst_out_d_ready", 128'(b2.out_d_ready), 128'h0);
         m_hold = -1;
         m_left = 0;
         m_ptr  = 0;
         return;
      end
      g = -1;
      if (m_hold >= 0) g = m_hold;
      else begin
         for (int k = 0; k < 2; k++) begin
            if (g < 0 && vld[(m_ptr + k) % 2]) g = (m_ptr + k) % 2;
         end
      end
      chk("out_a_valid", 128'(b2.out_a_valid), 128'(|vld));
      exp_rdy = (g >= 0 && b2.out_a_ready) ? (2'b01 << g) : 2'b00;
      chk("in_a_ready", 128'(b2.in_a_ready), 128'(exp_rdy));
      if (g >= 0 && aq[g].size() == 0) begin
         chk("grant_has_data", 128'h0, 128'h1);
         m_hold = -1;
      end else if (g >= 0) begin
         chk("out_a_bits", 128'(b2.out_a_bits), 128'(exp_out_a(aq[g][0], g[0])));
         if (b2.out_a_ready) begin
            fire_log.push_back(g);
            src_log.push_back(b2.out_a_bits[A_SRC +: 4]);
            if (m_left == 0) m_left = model_beats(aq[g][0]);
            m_left--;
            if (m_left == 0) begin
               m_hold = -1;
               m_ptr  = (g + 1) % 2;
            end else m_hold = g;
            void'(aq[g].pop_front());
         end else begin
            m_hold    = g;
            stall_src = b2.out_a_bits[A_SRC +: 4];
         end
      end
      didx   = b2.out_d_bits[D_SRC + SRC_W];
      dstrip = {b2.out_d_bits[D_W:D_SRC + SRC_W + 1], b2.out_d_bits[D_SRC + SRC_W - 1:0]};
      chk("in_d_valid", 128'(b2.in_d_valid), 128'(b2.out_d_valid ? (2'b01 << didx) : 2'b00));
      chk("out_d_ready", 128'(b2.out_d_ready), 128'(b2.in_d_ready[didx]));
      chk("in_d_bits0", 128'(b2.in_d_bits[D_W-1:0]), 128'(dstrip));
      chk("in_d_bits1", 128'(b2.in_d_bits[2*D_W-1:D_W]), 128'(dstrip));
      chk("route_err2", 128'(b2.route_err), 128'h0);
   endtask

   task automatic cycle();
      apply();
      @(negedge clk);
      check2();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      for (int t = 0; t < 40 && (aq[0].size() > 0 || aq[1].size() > 0); t++) cycle();
      chk(name, 128'(aq[0].size() + aq[1].size()), 128'h0);
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      n_checks = 0;
      n_errors = 0;
      m_hold = -1;
      m_left = 0;
      m_ptr  = 0;
      stall_src = 4'h0;
      b2.in_a_valid = '0;
      b2.in_a_bits = '0;
      b2.in_d_ready = 2'b11;
      b2.out_a_ready = 1'b1;
      b2.out_d_valid = 1'b0;
      b2.out_d_bits = '0;
      b3.in_a_valid = '0;
      b3.in_a_bits = '0;
      b3.in_d_ready = '0;
      b3.out_a_ready = 1'b0;
      b3.out_d_valid = 1'b0;
      b3.out_d_bits = '0;

      // reset: a requester is present but nothing may be offered
      aq[0].push_back(mk_a(3'd4, 3'd3, 3'd1, 64'h0));
      cycle();
      cycle();
      chk("rst_route_err3", 128'(b3.route_err), 128'h0);
      aq[0].delete();
      rst = 1'b0;

      // two continuous Gets per input alternate 0,1,0,1
      for (int k = 0; k < 2; k++) begin
         aq[0].push_back(mk_a(3'd4, 3'd3, 3'd2, 64'(k)));
         aq[1].push_back(mk_a(3'd4, 3'd3, 3'd5, 64'(k + 16)));
      end
      drain("t1_drain");
      chk("t1_order", 128'(order(0, 4)), 128'h0101);
      chk("t1_src0", 128'(src_log[0]), 128'h2);
      chk("t1_src1", 128'(src_log[1]), 128'hD);

      // 4-beat PutFull on input 0 is not interleaved with input 1
      for (int k = 0; k < 4; k++) aq[0].push_back(mk_a(3'd0, 3'd5, 3'd1, 64'hA0 + 64'(k)));
      aq[1].push_back(mk_a(3'd4, 3'd3, 3'd6, 64'h0));
      drain("t2_drain");
      chk("t2_order", 128'(order(4, 5)), 128'h00001);

      // stalled grant to input 1 survives input 0 raising valid
      b2.out_a_ready = 1'b0;
      aq[1].push_back(mk_a(3'd4, 3'd3, 3'd5, 64'h55));
      for (int k = 0; k < 3; k++) cycle();
      aq[0].push_back(mk_a(3'd4, 3'd3, 3'd3, 64'h66));
      cycle();
      chk("t3_stall_src", 128'(stall_src), 128'hD);
      b2.out_a_ready = 1'b1;
      drain("t3_drain");
      chk("t3_order", 128'(order(9, 2)), 128'h10);

      // D beat to client 1 back-pressured for two cycles
      b2.out_d_valid = 1'b1;
      b2.out_d_bits  = {3'd1, 2'd0, 3'd3, 4'b1101, 1'b0, 1'b0, 64'hDEAD_BEEF_0000_1234, 1'b0};
      b2.in_d_ready  = 2'b01;
      cycle();
      cycle();
      chk("t4_d_valid_hold", 128'(b2.in_d_valid), 128'h2);
      chk("t4_d_ready_hold", 128'(b2.out_d_ready), 128'h0);
      b2.in_d_ready = 2'b11;
      #1;
      chk("t4_d_ready_go", 128'(b2.out_d_ready), 128'h1);
      chk("t4_d_src", 128'(b2.in_d_bits[D_W + D_SRC +: 3]), 128'h5);
      cycle();
      b2.out_d_valid = 1'b0;

      // 3-input instance: index 2 routes, index 3 is swallowed and flagged
      b3.out_d_valid = 1'b1;
      b3.out_d_bits  = {3'd1, 2'd0, 3'd3, 5'b10_001, 1'b0, 1'b0, 64'h1, 1'b0};
      #1;
      chk("t5_idx2_valid", 128'(b3.in_d_valid), 128'h4);
      chk("t5_idx2_ready", 128'(b3.out_d_ready), 128'h0);
      b3.out_d_bits = {3'd1, 2'd0, 3'd3, 5'b11_001, 1'b0, 1'b0, 64'h2, 1'b0};
      #1;
      chk("t5_bad_ready", 128'(b3.out_d_ready), 128'h1);
      chk("t5_bad_valid", 128'(b3.in_d_valid), 128'h0);
      cycle();
      b3.out_d_valid = 1'b0;
      chk("t5_err_set", 128'(b3.route_err), 128'h1);
      cycle();
      cycle();
      chk("t5_err_sticky", 128'(b3.route_err), 128'h1);

      // reset after beat 2 of a 4-beat Put discards lock and pointer
      for (int k = 0; k < 4; k++) aq[0].push_back(mk_a(3'd0, 3'd5, 3'd2, 64'hC0 + 64'(k)));
      for (int t = 0; t < 10 && fire_log.size() < 13; t++) cycle();
      chk("t6_two_beats", 128'(fire_log.size()), 128'd13);
      rst = 1'b1;
      #1;
      chk("t6_err_cleared", 128'(b3.route_err), 128'h0);
      chk("t6_rst_valid", 128'(b2.out_a_valid), 128'h0);
      aq[0].delete();
      aq[0].push_back(mk_a(3'd4, 3'd3, 3'd4, 64'h7));
      aq[1].push_back(mk_a(3'd4, 3'd3, 3'd7, 64'h8));
      cycle();
      rst = 1'b0;
      drain("t6_drain");
      chk("t6_order", 128'(order(13, 2)), 128'h01);
      chk("t6_err_low", 128'(b3.route_err), 128'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/tl_xbar_nto1.md
# tl_xbar_nto1

Parametrised N-input to 1-output TileLink-UL crossbar that succeeds the single-port pass-through crossbar.
- A channel: arbitrates N client A channels onto one manager A channel, with round-robin fairness and burst locking; widens the source ID with the input index.
- D channel: routes manager responses back to the owning client by decoding and stripping that index.
- Sits between multiple masters (core front port, debug, DMA) and one slave port of the periphery bus.
- A TLMonitor per input is instantiated outside this block.

## Interface
Parameters:
- N_IN, 2, number of client ports (≥1)
- SRC_W, 3, client source ID width
- ADDR_W, 31, address width
- DATA_W, 64, data width (power of 2, ≥8); BEAT_LG = log2(DATA_W/8)
- SIZE_W, 3, size field width
- IDX_W (derived), max(1, clog2(N_IN)); OSRC_W = SRC_W + IDX_W

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- in_a_valid  in  N_IN  per-client A valid
- in_a_ready  out  N_IN  per-client A ready
- in_a_bits  in  N_IN*A_W  packed per client {opcode[3], param[3], size[SIZE_W], source[SRC_W], address[ADDR_W], mask[DATA_W/8], data[DATA_W], corrupt}
- in_d_valid  out  N_IN  per-client D valid
- in_d_ready  in  N_IN  per-client D ready
- in_d_bits  out  N_IN*D_W  packed per client {opcode[3], param[2], size[SIZE_W], source[SRC_W], sink, denied, data[DATA_W], corrupt}; identical copy on every lane
- out_a_valid / out_a_ready  out / in  1  manager A handshake
- out_a_bits  out  A_W+IDX_W  as in_a_bits, with source[OSRC_W] = {index, client source}
- out_d_valid / out_d_ready  in / out  1  manager D handshake
- out_d_bits  in  D_W+IDX_W  as in_d_bits, with source[OSRC_W]
- route_err  out  1  sticky: a D beat carried index ≥ N_IN

## Operation
A-channel arbitration:
- State: `rr_ptr` (IDX_W), `locked` (1), `owner` (IDX_W), `a_beats_left` (counter).
- Unlocked: grant the first valid input scanning from `rr_ptr` upward, wrapping modulo N_IN. `out_a_valid` = OR of the valids. Only the granted input sees `in_a_ready` = `out_a_ready`; all others see 0.
- If `out_a_valid` is high and the first beat does not fire, set `locked` and `owner` = grant. The grant stays fixed until that beat fires, so valid/bits never change while stalled.
- Beat count: opcodes 0–3 (Put/Atomic) with size > BEAT_LG carry 2^(size−BEAT_LG) beats. All other messages are 1 beat.
- When the first beat of a multi-beat message fires:
  - set `locked`, `owner`, and `a_beats_left` = beats−1;
  - each later fire decrements the counter;
  - the last beat clears `locked`.
- When the last beat of a message from input i fires: `rr_ptr` ← (i+1) mod N_IN.

D-channel routing:
- idx = out_d source[OSRC_W−1:SRC_W]; `in_d_valid[idx]` = `out_d_valid`, and `out_d_ready` = `in_d_ready[idx]`. The stripped source goes to every lane.
- idx ≥ N_IN (N_IN not a power of 2): the beat is accepted (`out_d_ready` = 1), no client sees valid, and `route_err` sets.
- The D path is combinational and stateless; AccessAckData bursts need no lock because the index is constant per beat.
- N_IN = 1: the index bit is driven 0, and the block degenerates to a pass-through.

## Timing
- A and D data paths have zero latency (combinational); only arbitration state is registered.
- Reset values: `rr_ptr` 0, `locked` 0, `a_beats_left` 0, `route_err` 0.
- While reset is asserted, `out_a_valid`, all `in_a_ready`, all `in_d_valid` and `out_d_ready` are 0.
- Reset mid-burst discards lock and count; arbitration restarts at input 0.
- Grant recomputes the same cycle `locked` falls. A new message from another input may fire the cycle after a last beat.
- No combinational path from `out_a_ready` to any `*_valid`.

## Structure
- Shared package `tl_xbar_pkg`:
  - TileLink opcode constants (PutFull 0, PutPartial 1, Arith 2, Logic 3, Get 4, AccessAck 0, AccessAckData 1);
  - function `tl_num_beats(opcode, size, BEAT_LG)`;
  - packed-field offset localparams.
- One sub-module: `tl_rr_arbiter` (N-way round-robin grant with lock input and one-hot/index outputs).

## Test plan
- N_IN=2: both inputs present a Get (size 3) continuously → grants alternate 0,1,0,1. out source = {0,s} then {1,s}.
- Input 0 PutFull size 5 (4 beats, DATA_W=64) while input 1 is valid → 4 consecutive input-0 beats, then input 1; no interleave.
- `out_a_ready` held 0 for 3 cycles with input 1 granted, then input 0 raises valid → out_a_bits unchanged, input 1 fires first.
- D beat with source {1,3'd5}, `in_d_ready[1]`=0 for 2 cycles → `in_d_valid[1]` held and `out_d_ready` 0. The beat is then accepted with source 5.
- N_IN=3, D source index 3 → `out_d_ready`=1, no `in_d_valid`, `route_err`=1 until reset.
- Assert reset after beat 2 of a 4-beat Put → after release, `rr_ptr`=0, unlocked, `route_err`=0, and input 1 can win immediately.
